// File: rtl/sram_responder_if.sv
// Pin bundle between an SRAM host and the device-side responder (all but the
// shared Data bus, which stays a plain inout so tristate resolution is local).
interface sram_responder_if #(
    parameter int ADDR_W = 20
);
    logic              CE_N;
    logic              OE_N;
    logic              WE_N;
    logic              UB_N;
    logic              LB_N;
    logic [ADDR_W-1:0] ADDR;
    logic              Contention;
    logic [15:0]       Rd_count;
    logic [15:0]       Wr_count;

    modport master (
        output CE_N, OE_N, WE_N, UB_N, LB_N, ADDR,
        input  Contention, Rd_count, Wr_count
    );

    modport slave (
        input  CE_N, OE_N, WE_N, UB_N, LB_N, ADDR,
        output Contention, Rd_count, Wr_count
    );
endinterface

// File: rtl/sram_responder.sv
// Device-side model of an asynchronous 16-bit SRAM: registered pin sampling,
// byte-lane writes, snapshot reads through an RD_LAT-deep drive pipeline.
module sram_responder #(
    parameter int N         = 16,
    parameter int ADDR_W    = 20,
    parameter int MEM_DEPTH = 1024,
    parameter int RD_LAT    = 1
) (
    input  logic            Clk,
    input  logic            Reset,
    sram_responder_if.slave bus,
    inout  wire  [N-1:0]    Data
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int LW = N / 2;

    logic              s_ce, s_oe, s_we, s_ub, s_lb, s_busy;
    logic [ADDR_W-1:0] s_addr;
    logic [N-1:0]      s_data;

    logic [N-1:0]             mem [MEM_DEPTH];
    logic [RD_LAT:1][N-1:0]   data_pipe;
    logic [RD_LAT:1][1:0]     en_pipe;

    logic        contention;
    logic [15:0] rd_count, wr_count;

    logic [AW-1:0] idx;
    logic [1:0]    lanes, drive;
    logic          wr_cyc, rd_cyc, wr_ok;
    logic          unused_hi;

    assign idx       = s_addr[AW-1:0];
    assign unused_hi = ^s_addr[ADDR_W-1:AW];
    assign lanes     = {~s_ub, ~s_lb};
    assign wr_cyc    = ~s_ce & ~s_we;
    assign rd_cyc    = ~s_ce & s_we & ~s_oe;
    // A write whose pins were sampled while we drove the bus carries garbage data.
    assign wr_ok     = wr_cyc & ~s_busy & (lanes != 2'b00);
    assign drive     = en_pipe[RD_LAT];

    assign Data[N-1:LW] = drive[1] ? data_pipe[RD_LAT][N-1:LW] : {(N-LW){1'bz}};
    assign Data[LW-1:0] = drive[0] ? data_pipe[RD_LAT][LW-1:0] : {LW{1'bz}};

    assign bus.Contention = contention;
    assign bus.Rd_count   = rd_count;
    assign bus.Wr_count   = wr_count;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            s_ce   <= 1'b1;
            s_oe   <= 1'b1;
            s_we   <= 1'b1;
            s_ub   <= 1'b1;
            s_lb   <= 1'b1;
            s_busy <= 1'b0;
            s_addr <= '0;
            s_data <= '0;
        end else begin
            s_ce   <= bus.CE_N;
            s_oe   <= bus.OE_N;
            s_we   <= bus.WE_N;
            s_ub   <= bus.UB_N;
            s_lb   <= bus.LB_N;
            s_busy <= |drive;
            s_addr <= bus.ADDR;
            s_data <= Data;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            en_pipe    <= '0;
            contention <= 1'b0;
            rd_count   <= '0;
            wr_count   <= '0;
        end else begin
            en_pipe[1] <= rd_cyc ? lanes : 2'b00;
            for (int k = 2; k <= RD_LAT; k++)
                en_pipe[k] <= en_pipe[k-1];
            if (wr_cyc && s_busy)
                contention <= 1'b1;
            if (wr_ok && wr_count != 16'hFFFF)
                wr_count <= wr_count + 16'd1;
            if (rd_cyc && rd_count != 16'hFFFF)
                rd_count <= rd_count + 16'd1;
        end
    end

    // Memory and read data carry no reset; validity lives in en_pipe.
    always_ff @(posedge Clk) begin
        data_pipe[1] <= mem[idx];
        for (int k = 2; k <= RD_LAT; k++)
            data_pipe[k] <= data_pipe[k-1];
        if (Reset && wr_ok) begin
            if (lanes[1]) mem[idx][N-1:LW] <= s_data[N-1:LW];
            if (lanes[0]) mem[idx][LW-1:0] <= s_data[LW-1:0];
        end
    end
endmodule

// File: tb/tb_sram_responder.sv
// Drives RD_LAT=1,2,3 responders with identical pin traffic and checks every
// cycle against a cycle-indexed transaction model of the SRAM.
module tb_sram_responder;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, ce_n, oe_n, we_n, ub_n, lb_n, host_en;
    logic [19:0] addr;
    logic [15:0] hdata;

    logic [15:0] obs  [NDUT];
    logic        cont [NDUT];
    logic [15:0] rdc  [NDUT];
    logic [15:0] wrc  [NDUT];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    for (genvar j = 0; j < NDUT; j++) begin : g
        sram_responder_if #(.ADDR_W(20)) ifc ();
        // Pull-ups make an undriven lane read back as all ones.
        tri1 [15:0] dbus;
        assign dbus     = host_en ? hdata : 16'hzzzz;
        assign ifc.CE_N = ce_n;
        assign ifc.OE_N = oe_n;
        assign ifc.WE_N = we_n;
        assign ifc.UB_N = ub_n;
        assign ifc.LB_N = lb_n;
        assign ifc.ADDR = addr;
        assign obs[j]   = dbus;
        assign cont[j]  = ifc.Contention;
        assign rdc[j]   = ifc.Rd_count;
        assign wrc[j]   = ifc.Wr_count;

        sram_responder #(.N(16), .ADDR_W(20), .MEM_DEPTH(1024), .RD_LAT(j + 1)) dut (
            .Clk   (clk),
            .Reset (rst_n),
            .bus   (ifc.slave),
            .Data  (dbus)
        );
    end

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        busy;
        logic [1:0]  lanes;
        logic [9:0]  idx;
        logic [15:0] d;
    } pend_t;

    logic [15:0] mmem [NDUT][1024];
    logic [15:0] dval [NDUT][4096];
    logic [1:0]  den  [NDUT][4096];
    pend_t       pend [NDUT];
    int          mrc  [NDUT];
    int          mwc  [NDUT];
    logic        mct  [NDUT];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Effect of edge number cyc: commit what was sampled one edge ago, then sample.
    task automatic model_edge();
        int    lat;
        pend_t p;
        cyc++;
        for (int j = 0; j < NDUT; j++) begin
            lat = j + 1;
            if (!rst_n) begin
                mrc[j] = 0;
                mwc[j] = 0;
                mct[j] = 1'b0;
                for (int c = cyc; c < cyc + 8; c++) den[j][c] = 2'b00;
                pend[j] = '0;
            end else begin
                p = pend[j];
                if (p.wr) begin
                    if (p.busy) mct[j] = 1'b1;
                    else if (p.lanes != 2'b00) begin
                        if (p.lanes[1]) mmem[j][p.idx][15:8] = p.d[15:8];
                        if (p.lanes[0]) mmem[j][p.idx][7:0]  = p.d[7:0];
                        if (mwc[j] < 65535) mwc[j]++;
                    end
                end
                if (p.rd) begin
                    if (mrc[j] < 65535) mrc[j]++;
                    dval[j][cyc - 1 + lat] = mmem[j][p.idx];
                    den[j][cyc - 1 + lat]  = p.lanes;
                end
                pend[j].rd    = !ce_n && we_n && !oe_n;
                pend[j].wr    = !ce_n && !we_n;
                pend[j].lanes = {!ub_n, !lb_n};
                pend[j].idx   = addr[9:0];
                pend[j].d     = hdata;
                pend[j].busy  = |den[j][cyc - 1];
            end
        end
    endtask

    task automatic check_all();
        logic [15:0] exp;
        for (int j = 0; j < NDUT; j++) begin
            exp[15:8] = den[j][cyc][1] ? dval[j][cyc][15:8] : 8'hFF;
            exp[7:0]  = den[j][cyc][0] ? dval[j][cyc][7:0]  : 8'hFF;
            if (!host_en) chk($sformatf("data L%0d c%0d", j + 1, cyc), obs[j], exp);
            chk($sformatf("rd_count L%0d c%0d", j + 1, cyc), rdc[j], 16'(mrc[j]));
            chk($sformatf("wr_count L%0d c%0d", j + 1, cyc), wrc[j], 16'(mwc[j]));
            chk($sformatf("contention L%0d c%0d", j + 1, cyc), {15'd0, cont[j]}, {15'd0, mct[j]});
        end
    endtask

    task automatic step(input logic r, c, o, w, u, l, input logic [19:0] a, input logic [15:0] d);
        rst_n   = r;
        ce_n    = c;
        oe_n    = o;
        we_n    = w;
        ub_n    = u;
        lb_n    = l;
        addr    = a;
        hdata   = d;
        host_en = r && !c && !w;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();                                step(1, 1, 1, 1, 1, 1, '0, '0);  endtask
    task automatic do_reset();                            step(0, 1, 1, 1, 1, 1, '0, '0);  endtask
    task automatic rd(input logic [19:0] a, input logic u, l); step(1, 0, 0, 1, u, l, a, '0); endtask
    task automatic wr(input logic [19:0] a, input logic [15:0] d, input logic u, l);
        step(1, 0, 1, 0, u, l, a, d);
    endtask

    initial begin
        for (int j = 0; j < NDUT; j++) begin
            pend[j] = '0;
            mrc[j]  = 0;
            mwc[j]  = 0;
            mct[j]  = 1'b0;
            for (int c = 0; c < 4096; c++) den[j][c] = 2'b00;
        end
        do_reset();
        do_reset();
        for (int j = 0; j < NDUT; j++) chk("reset_rd_count", rdc[j], 16'h0000);

        for (int i = 0; i < 16; i++) wr(20'(i), 16'(i), 0, 0);
        wr(5, 16'hBEEF, 0, 0);
        idle();
        rd(5, 0, 0);
        idle();
        chk("basic_beef", obs[0], 16'hBEEF);
        repeat (3) idle();

        wr(7, 16'h1234, 0, 0);
        wr(7, 16'hAB00, 0, 1);
        rd(7, 0, 1);
        idle();
        chk("byte_lane_upper_only", obs[0], 16'hABFF);
        repeat (3) idle();

        for (int i = 0; i < 4; i++) rd(20'(i), 0, 0);
        chk("stream_w0", obs[2], 16'h0000);
        for (int i = 1; i < 4; i++) begin
            idle();
            chk("stream_wn", obs[2], 16'(i));
        end
        idle();
        chk("stream_release", obs[2], 16'hFFFF);
        idle();

        wr(9, 16'h0011, 0, 0);
        repeat (3) idle();
        rd(9, 0, 0);
        wr(9, 16'h0022, 0, 0);
        idle();
        chk("snapshot_old", obs[1], 16'h0011);
        repeat (3) idle();
        rd(9, 0, 0);
        idle();
        chk("raw_new", obs[0], 16'h0022);
        repeat (3) idle();

        repeat (4) rd(9, 0, 0);
        wr(9, 16'h5555, 0, 0);
        idle();
        for (int j = 0; j < NDUT; j++) chk("contention_set", {15'd0, cont[j]}, 16'h0001);
        repeat (4) idle();
        rd(9, 0, 0);
        idle();
        chk("contention_dropped", obs[0], 16'h0022);
        repeat (3) idle();

        rd(9, 0, 0);
        idle();
        do_reset();
        for (int j = 0; j < NDUT; j++) chk("reset_wr_count", wrc[j], 16'h0000);
        repeat (4) idle();
        rd(9, 0, 0);
        idle();
        chk("mem_retained", obs[0], 16'h0022);
        repeat (3) idle();
        wr(20'd1024, 16'h7E57, 0, 0);
        idle();
        rd(0, 0, 0);
        idle();
        chk("addr_wrap", obs[0], 16'h7E57);
        repeat (3) idle();

        for (int n = 0; n < 400; n++) begin
            int          kind;
            logic [19:0] a;
            kind = $urandom_range(0, 99);
            a    = ($urandom & 20'hFFC00) | 20'($urandom_range(0, 15));
            if (kind < 3)       do_reset();
            else if (kind < 40) rd(a, 1'($urandom), 1'($urandom));
            else if (kind < 70) wr(a, 16'($urandom), 1'($urandom), 1'($urandom));
            else                step(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                                     1'($urandom), a, 16'($urandom));
        end
        repeat (5) idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
